cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the functional units fed by

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cdb_arbiter.sv | 77 +++++++
 tb/tb_cdb_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared types and sizes for the common data bus arbiter slice.
package cdb_pkg;

  localparam int unsigned WIDTH = 31;
  localparam int unsigned ROB   = 2;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned SRCW  = 2;

  typedef enum logic [SRCW-1:0] {
    SRC_ALU = 2'd0,
    SRC_BR  = 2'd1,
    SRC_AUX = 2'd2
  } src_e;

  typedef struct packed {
    logic [WIDTH:0] result;
    logic [ROB:0]   tag;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake plus CDB broadcast signals, bundled for the arbiter.
interface cdb_arbiter_if;
  import cdb_pkg::*;

  logic                        flush;
  logic [NREQ-1:0]             reqValid;
  logic [NREQ-1:0][WIDTH:0]    reqResult;
  logic [NREQ-1:0][ROB:0]      reqROB;
  logic [NREQ-1:0]             reqReady;
  logic                        cdbValid;
  logic [WIDTH:0]              cdbResult;
  logic [ROB:0]                cdbROB;
  logic [SRCW-1:0]             cdbSource;

  modport master (
    output flush, reqValid, reqResult, reqROB,
    input  reqReady, cdbValid, cdbResult, cdbROB, cdbSource
  );

  modport slave (
    input  flush, reqValid, reqResult, reqROB,
    output reqReady, cdbValid, cdbResult, cdbROB, cdbSource
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import cdb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [SRCW-1:0] gidx,
  output logic            any
);

  logic [SRCW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = SRCW'((32'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry buffer per functional unit, round-robin granted onto a registered
// CDB that feeds the ROB and reservation-station wakeup.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic          clk,
  input  logic          globalReset,
  cdb_arbiter_if.slave  bus
);

  logic [NREQ-1:0] buf_valid;
  cdb_entry_t      buf_q [NREQ];
  logic [SRCW-1:0] rr_ptr;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] acc;
  logic [SRCW-1:0] gidx;
  logic            any;

  logic            cdb_valid;
  cdb_entry_t      cdb_q;
  logic [SRCW-1:0] cdb_src;

  rr_arbiter u_rr (
    .req   (buf_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  // A buffer being drained this cycle can take a new result at the same edge.
  assign ready = ~buf_valid | grant;
  assign acc   = bus.reqValid & ready & {NREQ{~bus.flush}};

  assign bus.reqReady  = ready;
  assign bus.cdbValid  = cdb_valid;
  assign bus.cdbResult = cdb_q.result;
  assign bus.cdbROB    = cdb_q.tag;
  assign bus.cdbSource = cdb_src;

  always_ff @(posedge clk) begin
    if (globalReset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= SRC_ALU;
      for (int unsigned i = 0; i < NREQ; i++) begin
        buf_q[i] <= '0;
      end
    end else if (bus.flush) begin
      // Pointer is kept so fairness carries across the flush.
      buf_valid <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          buf_q[i]     <= cdb_entry_t'{result: bus.reqResult[i], tag: bus.reqROB[i]};
          buf_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (any) begin
        cdb_valid <= 1'b1;
        cdb_q     <= buf_q[gidx];
        cdb_src   <= gidx;
        rr_ptr    <= (gidx == SRCW'(NREQ - 1)) ? '0 : gidx + SRCW'(1);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue of expected CDB beats.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  typedef struct packed {
    logic       v;
    logic [1:0] src;
    logic [2:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic globalReset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk         (clk),
    .globalReset (globalReset),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] res(input logic [1:0] src, input logic [2:0] tag);
    return 32'hC0DE_0000 | (32'(src) << 8) | 32'(tag);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] v, input logic [2:0] t0,
                         input logic [2:0] t1, input logic [2:0] t2);
    bus.reqValid     = v;
    bus.reqROB[0]    = t0;
    bus.reqROB[1]    = t1;
    bus.reqROB[2]    = t2;
    bus.reqResult[0] = res(2'd0, t0);
    bus.reqResult[1] = res(2'd1, t1);
    bus.reqResult[2] = res(2'd2, t2);
  endtask

  task automatic expect_cdb(input logic v, input logic [1:0] src, input logic [2:0] tag);
    exp_t e;
    e.v   = v;
    e.src = src;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Advance one edge, then compare the CDB against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cdbValid", 32'(bus.cdbValid), 32'(e.v));
      if (e.v) begin
        chk("cdbSource", 32'(bus.cdbSource), 32'(e.src));
        chk("cdbROB", 32'(bus.cdbROB), 32'(e.tag));
        chk("cdbResult", bus.cdbResult, res(e.src, e.tag));
      end
    end
  endtask

  task automatic do_reset();
    globalReset = 1'b1;
    expect_cdb(1'b0, 2'd0, 3'd0);
    tick();
    globalReset = 1'b0;
  endtask

  initial begin
    globalReset = 1'b1;
    bus.flush   = 1'b0;
    set_req(3'b000, 3'd0, 3'd0, 3'd0);

    // Reset held two cycles while every unit requests.
    set_req(3'b111, 3'd1, 3'd2, 3'd3);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    globalReset = 1'b0;
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    chk("ready_after_reset", 32'(bus.reqReady), 32'h7);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Single ALU stream at full rate.
    set_req(3'b001, 3'd1, 3'd0, 3'd0);
    chk("alu_ready_t1", 32'(bus.reqReady[0]), 32'd1);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    set_req(3'b001, 3'd2, 3'd0, 3'd0);
    chk("alu_ready_t2", 32'(bus.reqReady[0]), 32'd1);
    expect_cdb(1'b1, 2'd0, 3'd1); tick();
    set_req(3'b001, 3'd3, 3'd0, 3'd0);
    chk("alu_ready_t3", 32'(bus.reqReady[0]), 32'd1);
    expect_cdb(1'b1, 2'd0, 3'd2); tick();
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    expect_cdb(1'b1, 2'd0, 3'd3); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Three-way contention from rrPtr=0.
    do_reset();
    set_req(3'b111, 3'd4, 3'd5, 3'd6);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    chk("cont_ready_0", 32'(bus.reqReady), 32'h1);
    expect_cdb(1'b1, 2'd0, 3'd4); tick();
    chk("cont_ready_1", 32'(bus.reqReady), 32'h3);
    expect_cdb(1'b1, 2'd1, 3'd5); tick();
    chk("cont_ready_2", 32'(bus.reqReady), 32'h7);
    expect_cdb(1'b1, 2'd2, 3'd6); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Fairness: ALU keeps requesting, branch has one result (tag 7).
    set_req(3'b011, 3'd0, 3'd7, 3'd0);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    set_req(3'b001, 3'd1, 3'd0, 3'd0);
    chk("fair_alu_ready_a", 32'(bus.reqReady[0]), 32'd1);
    expect_cdb(1'b1, 2'd0, 3'd0); tick();
    set_req(3'b001, 3'd2, 3'd0, 3'd0);
    chk("fair_alu_blocked", 32'(bus.reqReady[0]), 32'd0);
    expect_cdb(1'b1, 2'd1, 3'd7); tick();
    chk("fair_alu_ready_b", 32'(bus.reqReady[0]), 32'd1);
    expect_cdb(1'b1, 2'd0, 3'd1); tick();
    set_req(3'b001, 3'd3, 3'd0, 3'd0);
    expect_cdb(1'b1, 2'd0, 3'd2); tick();
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    expect_cdb(1'b1, 2'd0, 3'd3); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Flush drops buffered tags 1/2 and the AUX request of the flush cycle.
    set_req(3'b011, 3'd1, 3'd2, 3'd0);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    bus.flush = 1'b1;
    set_req(3'b100, 3'd0, 3'd0, 3'd4);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    bus.flush = 1'b0;
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    chk("flush_ready", 32'(bus.reqReady), 32'h7);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Branch refilled in the same cycle it is granted.
    set_req(3'b010, 3'd0, 3'd3, 3'd0);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    set_req(3'b010, 3'd0, 3'd5, 3'd0);
    chk("refill_ready", 32'(bus.reqReady[1]), 32'd1);
    expect_cdb(1'b1, 2'd1, 3'd3); tick();
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    expect_cdb(1'b1, 2'd1, 3'd5); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();

    // Reset and flush together: reset clears rrPtr (it is 2 here).
    globalReset = 1'b1;
    bus.flush   = 1'b1;
    set_req(3'b001, 3'd1, 3'd0, 3'd0);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    globalReset = 1'b0;
    bus.flush   = 1'b0;
    set_req(3'b101, 3'd4, 3'd0, 3'd6);
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    set_req(3'b000, 3'd0, 3'd0, 3'd0);
    expect_cdb(1'b1, 2'd0, 3'd4); tick();
    expect_cdb(1'b1, 2'd2, 3'd6); tick();
    expect_cdb(1'b0, 2'd0, 3'd0); tick();
    chk("final_ready", 32'(bus.reqReady), 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
